// File: rtl/qc12864_bus_writer.sv
// -----------------------------------------------------------------------------
// qc12864_bus_writer
//
// Write-only parallel-bus engine for the QC12864 (ST7920) LCD controller.
// Accepts one 16-bit command word per valid/ready handshake. It drives
// RS/DB, then pulses E with the controller's setup, strobe and hold timing.
// It then waits out the instruction execution time before accepting the
// next word. Clear Display (instruction 0x01) gets the long execution wait.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous reset, active-high
//   cmd_in     [8]=RS (1 data, 0 instruction), [7:0]=byte, [15:9] ignored
//   cmd_valid  cmd_in valid
//   cmd_ready  word can be accepted this cycle (0 while rst is high)
//   busy       transfer or execution wait in progress
//   done       one-cycle pulse when a word's execution wait completes
//   lcd_rs     register select
//   lcd_rw     read/write, tied to write (0)
//   lcd_e      enable strobe, registered
//   lcd_db     data bus
// -----------------------------------------------------------------------------
module qc12864_bus_writer #(
   parameter int T_SETUP     = 4,
   parameter int T_EHIGH     = 16,
   parameter int T_HOLD      = 4,
   parameter int T_EXEC      = 4000,
   parameter int T_EXEC_LONG = 80000,
   parameter int CNT_W       = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cmd_in,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   output logic        busy,
   output logic        done,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        lcd_e,
   output logic [7:0]  lcd_db
);

   // A zero duration would make a phase vanish, so it is clamped to one cycle.
   localparam int SETUP_EFF = (T_SETUP     < 1) ? 1 : T_SETUP;
   localparam int EHIGH_EFF = (T_EHIGH     < 1) ? 1 : T_EHIGH;
   localparam int HOLD_EFF  = (T_HOLD      < 1) ? 1 : T_HOLD;
   localparam int EXEC_EFF  = (T_EXEC      < 1) ? 1 : T_EXEC;
   localparam int LONG_EFF  = (T_EXEC_LONG < 1) ? 1 : T_EXEC_LONG;

   // The timer counts down to zero, so a phase of N cycles loads N-1.
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_EFF - 1);
   localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(EHIGH_EFF - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_EFF - 1);
   localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_EFF - 1);
   localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_EFF - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_EXEC   = 3'd4
   } state_t;

   state_t           state_r, state_s;
   logic [CNT_W-1:0] timer_r, timer_s;
   logic             long_r, long_s;
   logic             rs_r, rs_s;
   logic [7:0]       db_r, db_s;
   logic             e_r;
   logic             done_r, done_s;
   logic             accept_s;
   logic             timer_zero_s;
   logic             unused_hi_s;

   // Bits [15:9] of the word carry no meaning for the bus.
   assign unused_hi_s = ^cmd_in[15:9];

   assign cmd_ready    = (state_r == ST_IDLE) && !rst;
   assign busy         = (state_r != ST_IDLE) && !rst;
   assign accept_s     = cmd_valid && cmd_ready;
   assign timer_zero_s = (timer_r == {CNT_W{1'b0}});

   assign done   = done_r;
   assign lcd_rs = rs_r;
   assign lcd_rw = 1'b0;
   assign lcd_e  = e_r;
   assign lcd_db = db_r;

   // Next-state, timer reload and word-latch logic.
   always_comb begin
      state_s = state_r;
      timer_s = timer_r;
      long_s  = long_r;
      rs_s    = rs_r;
      db_s    = db_r;
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               rs_s    = cmd_in[8];
               db_s    = cmd_in[7:0];
               // Clear Display is the only instruction with the long wait.
               long_s  = !cmd_in[8] && (cmd_in[7:0] == 8'h01);
               timer_s = SETUP_LD;
               state_s = ST_SETUP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (timer_zero_s) begin
               timer_s = EHIGH_LD;
               state_s = ST_STROBE;
            end else begin
               timer_s = timer_r - CNT_W'(1);
            end
         end
         ST_STROBE: begin
            if (timer_zero_s) begin
               timer_s = HOLD_LD;
               state_s = ST_HOLD;
            end else begin
               timer_s = timer_r - CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (timer_zero_s) begin
               timer_s = long_r ? LONG_LD : EXEC_LD;
               state_s = ST_EXEC;
            end else begin
               timer_s = timer_r - CNT_W'(1);
            end
         end
         ST_EXEC: begin
            if (timer_zero_s) begin
               timer_s = {CNT_W{1'b0}};
               done_s  = 1'b1;
               state_s = ST_IDLE;
            end else begin
               timer_s = timer_r - CNT_W'(1);
            end
         end
         default: begin
            timer_s = {CNT_W{1'b0}};
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, timer and registered bus outputs; E follows the next state so it
   // is a clean flop output aligned with the STROBE phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         timer_r <= {CNT_W{1'b0}};
         long_r  <= 1'b0;
         rs_r    <= 1'b0;
         db_r    <= 8'h00;
         e_r     <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         timer_r <= timer_s;
         long_r  <= long_s;
         rs_r    <= rs_s;
         db_r    <= db_s;
         e_r     <= (state_s == ST_STROBE);
         done_r  <= done_s;
      end
   end

endmodule

// File: doc/qc12864_bus_writer.md
Name: qc12864_bus_writer

Overview:
Parallel-bus write engine for the QC12864 (ST7920) LCD; the consuming end of the 16-bit command words produced by the GDRAM/DDRAM initializer and drawing logic. It accepts one word per valid/ready handshake and drives RS/RW/E/DB[7:0] with the controller's setup, strobe and hold timing. It then waits out the instruction execution time before accepting the next word. The bus is write-only; busy-flag polling is not used.

Parameters:
T_SETUP, 4, cycles RS/DB stable before E rises (0 treated as 1)
T_EHIGH, 16, cycles E held high (0 treated as 1)
T_HOLD, 4, cycles RS/DB held after E falls (0 treated as 1)
T_EXEC, 4000, execution wait for normal instructions/data (80 us at 50 MHz; 0 treated as 1)
T_EXEC_LONG, 80000, execution wait for Clear Display (1.6 ms at 50 MHz; 0 treated as 1)
CNT_W, 17, timer width; must hold max(T_*)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
cmd_in  in  16  word: [8]=RS (1 data, 0 instruction), [7:0]=byte, [15:9] ignored
cmd_valid  in  1  cmd_in valid
cmd_ready  out  1  block can accept a word this cycle
busy  out  1  transfer or execution wait in progress (= ~cmd_ready outside reset)
done  out  1  one-cycle pulse when a word's execution wait completes
lcd_rs  out  1  register select
lcd_rw  out  1  read/write, constant 0
lcd_e  out  1  enable strobe
lcd_db  out  8  data bus

Behaviour:
- One clock, synchronous active-high reset. Reset values: state IDLE, cmd_ready=1 on the first cycle after reset release (0 while rst=1), busy=0, done=0, lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_db=0, timer=0.
- States: IDLE, SETUP, STROBE, HOLD, EXEC.
- IDLE: cmd_ready=1. Accept on posedge where cmd_valid && cmd_ready. Latch cmd_in[8] into lcd_rs and cmd_in[7:0] into lcd_db. Set long_flag = (cmd_in[8]==0 && cmd_in[7:0]==8'h01). Go to SETUP. Without an accept, lcd_rs/lcd_db keep their last values.
- SETUP: lcd_e=0 for exactly T_SETUP cycles, then STROBE.
- STROBE: lcd_e=1 for exactly T_EHIGH cycles, then HOLD. lcd_e is registered and glitch-free.
- HOLD: lcd_e=0 and RS/DB unchanged for exactly T_HOLD cycles, then EXEC.
- EXEC: wait exactly T_EXEC_LONG cycles if long_flag, else T_EXEC, then IDLE. done=1 on the first IDLE cycle only.
- Latency: accept at edge k gives E high on cycles k+1+T_SETUP … k+T_SETUP+T_EHIGH. cmd_ready returns on cycle k+1+T_SETUP+T_EHIGH+T_HOLD+T_EXEC(_LONG).
- Back-to-back: with cmd_valid held high, the next accept occurs in the same cycle done pulses (no extra bubble).
- cmd_valid or cmd_in changing while busy is ignored. Words are not queued, and the producer must hold cmd_valid until accepted.
- Bits [15:9] have no effect, including in long_flag decode.
- Timer counts down from the loaded value. No wrap: it loads fresh on every state entry.
- rst asserted in any state: next cycle IDLE with all outputs at reset values. No done for the aborted word, and lcd_e drops to 0 immediately even mid-strobe.
- lcd_rw never leaves 0.

Test Plan:
(Sim parameters: T_SETUP=2, T_EHIGH=3, T_HOLD=2, T_EXEC=5, T_EXEC_LONG=20.)
- After reset, cmd_in=16'h0034 with valid accepted at edge k -> lcd_rs=0, lcd_db=8'h34 from k+1. lcd_e=1 exactly on cycles k+3..k+5. done=1 and cmd_ready=1 on cycle k+13 only.
- cmd_in=16'h0100 (data 0x00) -> lcd_rs=1, lcd_db=8'h00, same timing as above. lcd_rw=0 throughout.
- cmd_in=16'h0001 -> long wait: cmd_ready returns at k+28. cmd_in=16'h0101 (data 0x01) -> normal wait, return at k+13.
- cmd_valid held high with 4 words 0x0034, 0x0036, 0x0080, 0x0080 -> accepts exactly 13 cycles apart, each strobe 3 cycles, no dropped or duplicated word. Toggling cmd_in while busy leaves lcd_db unchanged.
- rst pulsed during STROBE -> next cycle lcd_e=0, lcd_db=0, cmd_ready=1 after release, no done. A following word completes normally.
- cmd_in=16'hFE01 -> treated as Clear Display (long wait). Upper bits are ignored.
